tim_apb_master: RTL and testbench

//  APB4 requester that drives the timer's APB slave port (the register set behind tim_paddr/tim_pwdata/tim_pstrb/tim_prdata).

---
 rtl/tim_apb_master.sv | 150 +++++++++++++++
 tb/tb_tim_apb_master.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tim_apb_master.sv
// APB4 requester for the timer register port: one valid/ready command in, one SETUP/ACCESS transfer out.
// Optional ACCESS timeout is enabled with `define TIM_APB_TIMEOUT_EN.
module tim_apb_master #(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic                  tim_psel,
  output logic                  tim_penable,
  output logic                  tim_pwrite,
  output logic [ADDR_W-1:0]     tim_paddr,
  output logic [DATA_W-1:0]     tim_pwdata,
  output logic [DATA_W/8-1:0]   tim_pstrb,
  input  logic [DATA_W-1:0]     tim_prdata,
  input  logic                  tim_pready,
  input  logic                  tim_pslverr
);

  localparam int unsigned STRB_W = DATA_W / 8;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t state_q, state_d;
  logic   accept_c;
  logic   done_c;
  logic   tout_c;
  logic   tout_hit_c;

  assign accept_c = (state_q == S_IDLE) && cmd_valid && cmd_ready;

`ifdef TIM_APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] acc_cnt_q;

  // Counts completed ACCESS cycles of the current transfer.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc_cnt_q <= '0;
    end else if (state_d == S_SETUP) begin
      acc_cnt_q <= '0;
    end else if (state_q == S_ACCESS) begin
      acc_cnt_q <= acc_cnt_q + CNT_W'(1);
    end
  end

  assign tout_hit_c = (acc_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tout_hit_c  = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next state; a ready in the timeout cycle takes priority.
  always_comb begin
    state_d = state_q;
    done_c  = 1'b0;
    tout_c  = 1'b0;
    case (state_q)
      S_IDLE:   if (accept_c) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (tim_pready) begin
          done_c  = 1'b1;
          state_d = S_RESP;
        end else if (tout_hit_c) begin
          tout_c  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Registered handshake and APB control, decoded from the next state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      tim_psel    <= 1'b0;
      tim_penable <= 1'b0;
      rsp_valid   <= 1'b0;
    end else begin
      cmd_ready   <= (state_d == S_IDLE);
      busy        <= (state_d != S_IDLE);
      tim_psel    <= (state_d == S_SETUP) || (state_d == S_ACCESS);
      tim_penable <= (state_d == S_ACCESS);
      rsp_valid   <= (state_d == S_RESP);
    end
  end

  // Transfer payload is latched once and held until the next command.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tim_pwrite <= 1'b0;
      tim_paddr  <= '0;
      tim_pwdata <= '0;
      tim_pstrb  <= '0;
    end else if (accept_c) begin
      tim_pwrite <= cmd_write;
      tim_paddr  <= cmd_addr & ~ADDR_W'(3);
      tim_pwdata <= cmd_wdata;
      tim_pstrb  <= cmd_write ? cmd_strb : STRB_W'(0);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (done_c) begin
      rsp_rdata <= tim_pwrite ? DATA_W'(0) : tim_prdata;
      rsp_err   <= tim_pslverr;
    end else if (tout_c) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b1;
    end
  end

`ifdef TIM_APB_TIMEOUT_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  rsp_timeout <= 1'b0;
    else if (done_c) rsp_timeout <= 1'b0;
    else if (tout_c) rsp_timeout <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_tim_apb_master.sv
// Scoreboard bench for tim_apb_master: directed commands, APB slave model, response monitor.
module tb_tim_apb_master;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  logic        tim_psel;
  logic        tim_penable;
  logic        tim_pwrite;
  logic [11:0] tim_paddr;
  logic [31:0] tim_pwdata;
  logic [3:0]  tim_pstrb;
  logic [31:0] tim_prdata = '0;
  logic        tim_pready = 1'b0;
  logic        tim_pslverr = 1'b0;

  tim_apb_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
    .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
    .tim_prdata(tim_prdata), .tim_pready(tim_pready), .tim_pslverr(tim_pslverr)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tout;
  } resp_t;

  resp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Expected APB payload for the transfer in flight
  logic        exp_pwrite;
  logic [11:0] exp_paddr;
  logic [31:0] exp_pwdata;
  logic [3:0]  exp_pstrb;
  int          slv_wait = 0;
  int          acc_n = 0;
  int          acc_last = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // APB slave: ready after slv_wait stalled ACCESS cycles; checks payload on every selected cycle.
  always @(negedge sys_clk) begin
    if (tim_psel) begin
      chk("paddr", 32'(tim_paddr), 32'(exp_paddr));
      chk("pwrite", 32'(tim_pwrite), 32'(exp_pwrite));
      chk("pwdata", tim_pwdata, exp_pwdata);
      chk("pstrb", 32'(tim_pstrb), 32'(exp_pstrb));
    end
    if (tim_psel && tim_penable) begin
      acc_n++;
      acc_last = acc_n;
    end else begin
      acc_n = 0;
    end
    tim_pready = tim_psel && tim_penable && (acc_n > slv_wait);
  end

  // Response monitor
  always begin
    @(negedge sys_clk);
    #1;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b tout=%b expected none", rsp_rdata, rsp_err, rsp_timeout);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(e.tout));
      end
    end
  end

  // Issue one command from a negedge; returns at the negedge after acceptance (SETUP visible).
  task automatic send(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input int wt, input logic [31:0] prd, input logic serr,
                      input logic push, input logic [31:0] e_rd, input logic e_err, input logic e_to);
    int n;
    slv_wait    = wt;
    tim_prdata  = prd;
    tim_pslverr = serr;
    exp_pwrite  = wr;
    exp_paddr   = addr & 12'hFFC;
    exp_pwdata  = wd;
    exp_pstrb   = wr ? st : 4'h0;
    acc_last    = 0;
    if (push) exp_q.push_back('{rdata: e_rd, err: e_err, tout: e_to});
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_strb  = st;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    if (n == 50) chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge sys_clk);
    @(negedge sys_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    if (n == 100) chk("rsp_wait_timeout", 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    #2;
    chk("rst_psel", 32'(tim_psel), 32'd0);
    chk("rst_penable", 32'(tim_penable), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_paddr", 32'(tim_paddr), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // 1: write with immediate ready, minimum latency
    send(1'b1, 12'h00C, 32'h1234_5678, 4'hF, 0, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    chk("t1_setup_psel", 32'(tim_psel), 32'd1);
    chk("t1_setup_penable", 32'(tim_penable), 32'd0);
    chk("t1_setup_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("t1_setup_busy", 32'(busy), 32'd1);
    @(negedge sys_clk);
    chk("t1_access_psel", 32'(tim_psel), 32'd1);
    chk("t1_access_penable", 32'(tim_penable), 32'd1);
    @(negedge sys_clk);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_resp_psel", 32'(tim_psel), 32'd0);
    chk("t1_hold_paddr", 32'(tim_paddr), 32'h00C);
    @(negedge sys_clk);

    // 2: read with three wait states
    send(1'b0, 12'h004, 32'hAAAA_5555, 4'hF, 3, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    wait_rsp();
    chk("t2_access_cycles", 32'(acc_last), 32'd4);
    @(negedge sys_clk);

    // 3: slave error on write
    send(1'b1, 12'h000, 32'h0000_0900, 4'h2, 0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0);
    wait_rsp();
    @(negedge sys_clk);

    // Unaligned address is forced to word alignment
    send(1'b1, 12'h01B, 32'hCAFE_0001, 4'h9, 1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    wait_rsp();
    @(negedge sys_clk);

    // 4: response back-pressure with a pending command
    rsp_ready = 1'b0;
    send(1'b0, 12'h008, 32'h0, 4'h0, 0, 32'h55AA_1234, 1'b0, 1'b1, 32'h55AA_1234, 1'b0, 1'b0);
    wait_rsp();
    tim_prdata = 32'h0BAD_F00D;
    exp_pwrite = 1'b0;
    exp_paddr  = 12'h014;
    exp_pwdata = 32'h0;
    exp_pstrb  = 4'h0;
    exp_q.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0, tout: 1'b0});
    cmd_write = 1'b0;
    cmd_addr  = 12'h014;
    cmd_wdata = 32'h0;
    cmd_strb  = 4'hF;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t4_hold_rdata", rsp_rdata, 32'h55AA_1234);
      chk("t4_hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("t4_hold_psel", 32'(tim_psel), 32'd0);
      @(negedge sys_clk);
    end
    rsp_ready = 1'b1;
    @(negedge sys_clk);
    chk("t4_idle_psel", 32'(tim_psel), 32'd0);
    chk("t4_idle_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge sys_clk);
    chk("t4_next_setup_psel", 32'(tim_psel), 32'd1);
    chk("t4_next_setup_penable", 32'(tim_penable), 32'd0);
    cmd_valid = 1'b0;
    wait_rsp();
    @(negedge sys_clk);

    // 5: asynchronous reset during ACCESS
    send(1'b1, 12'h010, 32'h1111_2222, 4'hF, 1000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge sys_clk);
    chk("t5_in_access", 32'(tim_penable), 32'd1);
    #3 sys_rst_n = 1'b0;
    #1;
    chk("t5_rst_psel", 32'(tim_psel), 32'd0);
    chk("t5_rst_penable", 32'(tim_penable), 32'd0);
    chk("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    slv_wait  = 0;
    @(negedge sys_clk);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_cmd_ready", 32'(cmd_ready), 32'd1);

`ifdef TIM_APB_TIMEOUT_EN
    // 6: timeout after 16 stalled ACCESS cycles
    send(1'b0, 12'h018, 32'h0, 4'h0, 1000, 32'h7777_7777, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
    wait_rsp();
    chk("t6_access_cycles", 32'(acc_last), 32'd16);
    chk("t6_psel", 32'(tim_psel), 32'd0);
    @(negedge sys_clk);
    // Ready on the final allowed cycle wins over timeout
    send(1'b0, 12'h01C, 32'h0, 4'h0, 15, 32'h3C3C_3C3C, 1'b0, 1'b1, 32'h3C3C_3C3C, 1'b0, 1'b0);
    wait_rsp();
    chk("t6_ready_wins_cycles", 32'(acc_last), 32'd16);
    @(negedge sys_clk);
`endif

    repeat (4) @(negedge sys_clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
